or_gate: RTL and testbench
==========================

# or_gate

Two-input bitwise OR block with a combinational result and a registered copy. It is a leaf primitive in the gates library, used wherever a logic-level OR is needed. It also supplies a clock-aligned OR result and a sticky activity flag for downstream synchronous logic. The combinational path matches the plain OR truth table exactly; the registered outputs add one cycle of latency.

## Interface
- WIDTH, default 1: bit width of operands and results; legal range 1 to 64.
- clk  input  1  single system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c  output  WIDTH  combinational a | b.
- c_q  output  WIDTH  registered a | b.
- any_q  output  1  sticky flag: set once any bit of a | b has been 1 since the last reset.
- clr  input  1  synchronous clear of any_q only.

## Operation
- c = a | b bitwise, purely combinational.
- c is independent of clk, rst and clr, and is valid during reset.
- Truth table per bit, as (a, b) -> c: 00 -> 0, 10 -> 1, 01 -> 1, 11 -> 1.
- c_q captures a | b on every rising clk edge when rst = 0.
- any_q update, per rising edge, in priority order:
  - rst = 1: any_q <= 0.
  - else clr = 1: any_q <= 0. clr wins over a same-cycle set, and the set is lost.
  - else |(a | b) = 1: any_q <= 1.
  - otherwise any_q holds.
- X or Z on an input bit propagates per standard 4-state OR semantics. A 1 on either input forces that result bit to 1.

## Timing
- c: zero-cycle latency; follows the inputs with combinational delay only.
- c_q: one-cycle latency. The value after edge n equals a | b sampled at edge n.
- Reset values: c_q = 0 (all bits) and any_q = 0 after any edge with rst = 1.
- Reset mid-operation: the next edge forces both c_q and any_q to 0 regardless of inputs.
- After reset: c_q resumes on the first edge with rst = 0.
- No handshake and no back-pressure; a new input may be applied every cycle.

## Structure
- Shared gates package holds:
  - WIDTH_DEFAULT = 1.
  - A typedef for the WIDTH-bit data word, shared by all gate blocks.
- Natural sub-module or2_cell: purely combinational per-bit OR, instantiated WIDTH times in a generate loop to form c.
- Registers (c_q, any_q) live in the top block.

## Test plan
- Truth-table sweep, WIDTH = 1: apply (a, b) = (0,0), (1,0), (0,1), (1,1), 5 time units apart, no clock needed -> c = 0, 1, 1, 1 at each step.
- Registered path, WIDTH = 8: a = 8'hA0, b = 8'h05 at edge n -> c = 8'hA5 immediately, and c_q = 8'hA5 after edge n; c_q = 0 before edge n.
- Reset:
  - Drive a = b = 8'hFF with rst = 1 for 2 edges -> c = 8'hFF, c_q = 0, any_q = 0.
  - Deassert rst -> c_q = 8'hFF and any_q = 1 after the next edge.
- Sticky flag:
  - a = b = 0 for 3 edges -> any_q = 0.
  - One cycle with b = 8'h01 -> any_q = 1 and stays 1 after the inputs return to 0.
- Clear priority:
  - clr = 1 on the same edge as a = 8'h80 -> any_q = 0.
  - Next edge with clr = 0 and a = 8'h80 -> any_q = 1.
- Mid-operation reset: with any_q = 1 and c_q = 8'h3C, pulse rst for one edge -> both become 0 on that edge, while c still tracks a | b.

Source files
------------

// File: rtl/or_gate_pkg.sv
// Shared gates-library types and constants.
// Gate blocks size their ports from WIDTH and slice word_t when they need a container.
package or_gate_pkg;

  localparam int WIDTH_DEFAULT = 1;
  localparam int MAX_WIDTH     = 64;

  // Widest data word in the library; a WIDTH-bit block uses word_t[WIDTH-1:0].
  typedef logic [MAX_WIDTH-1:0] word_t;

endpackage

// File: rtl/or_gate_if.sv
// Operand/result bundle for or_gate; the driver side is master, the gate is slave.
interface or_gate_if
  import or_gate_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             clr;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] c_q;
  logic             any_q;

  modport master (output a, b, clr, input c, c_q, any_q);
  modport slave  (input a, b, clr, output c, c_q, any_q);
endinterface

// File: rtl/or_gate_or2_cell.sv
// Single-bit combinational OR; 4-state semantics come straight from the operator.
module or2_cell (
  input  logic a_i,
  input  logic b_i,
  output logic c_o
);
  assign c_o = a_i | b_i;
endmodule

// File: rtl/or_gate.sv
// WIDTH-bit OR with a combinational result, a registered copy and a sticky
// "any bit seen high" flag.
module or_gate
  import or_gate_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  or_gate_if.slave   bus
);

  logic [WIDTH-1:0] c_w;
  logic [WIDTH-1:0] c_q_d, c_q_q;
  logic             any_q_d, any_q_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    or2_cell u_cell (
      .a_i (bus.a[i]),
      .b_i (bus.b[i]),
      .c_o (c_w[i])
    );
  end

  assign bus.c = c_w;

  // clr beats a same-cycle set, so the set is dropped rather than deferred.
  always_comb begin
    c_q_d   = c_w;
    any_q_d = any_q_q;
    if (bus.clr)   any_q_d = 1'b0;
    else if (|c_w) any_q_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      c_q_q   <= '0;
      any_q_q <= 1'b0;
    end else begin
      c_q_q   <= c_q_d;
      any_q_q <= any_q_d;
    end
  end

  assign bus.c_q   = c_q_q;
  assign bus.any_q = any_q_q;

endmodule

// File: tb/tb_or_gate.sv
// Directed-vector bench for or_gate: stimulus pushes expectations, a negedge
// monitor pops and compares.
module tb_or_gate;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  or_gate_if #(.WIDTH(8)) bus8 ();
  or_gate_if #(.WIDTH(1)) bus1 ();

  or_gate #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));
  or_gate #(.WIDTH(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  typedef struct {
    string      nm;
    bit         w1;       // check the 1-bit instance's c only
    logic [7:0] c;
    logic [7:0] cq;
    logic       any;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input string fld, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      if (e.w1) begin
        chk(e.nm, "c", {7'b0, bus1.c}, e.c);
      end else begin
        chk(e.nm, "c",     bus8.c,            e.c);
        chk(e.nm, "c_q",   bus8.c_q,          e.cq);
        chk(e.nm, "any_q", {7'b0, bus8.any_q}, {7'b0, e.any});
      end
    end
  end

  // Drive inputs, let one rising edge sample them, expect the post-edge state.
  task automatic step(input string nm, input logic r, input logic cl,
                      input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] ec, input logic [7:0] ecq, input logic eany);
    exp_t e;
    rst      = r;
    bus8.clr = cl;
    bus8.a   = a;
    bus8.b   = b;
    @(posedge clk);
    e.nm = nm; e.w1 = 1'b0; e.c = ec; e.cq = ecq; e.any = eany;
    sb.push_back(e);
    @(negedge clk);
    #1;
  endtask

  task automatic tt(input string nm, input logic a, input logic b, input logic ec);
    exp_t e;
    bus1.a = a;
    bus1.b = b;
    e.nm = nm; e.w1 = 1'b1; e.c = {7'b0, ec}; e.cq = '0; e.any = 1'b0;
    sb.push_back(e);
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst      = 1'b1;
    bus1.clr = 1'b0;
    bus1.a   = 1'b0;
    bus1.b   = 1'b0;

    // reset holds registers low while c still follows the inputs
    step("rst0",     1, 0, 8'hFF, 8'hFF, 8'hFF, 8'h00, 0);
    step("rst1",     1, 0, 8'hFF, 8'hFF, 8'hFF, 8'h00, 0);
    step("rst_rel",  0, 0, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1);
    step("clr_idle", 0, 1, 8'h00, 8'h00, 8'h00, 8'h00, 0);

    // sticky flag
    step("quiet0",   0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    step("quiet1",   0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    step("quiet2",   0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 0);
    step("b_pulse",  0, 0, 8'h00, 8'h01, 8'h01, 8'h01, 1);
    step("hold0",    0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1);
    step("hold1",    0, 0, 8'h00, 8'h00, 8'h00, 8'h00, 1);

    // registered path
    step("reg_a5",   0, 0, 8'hA0, 8'h05, 8'hA5, 8'hA5, 1);
    step("reg_5a",   0, 0, 8'h50, 8'h0A, 8'h5A, 8'h5A, 1);

    // clear beats a same-cycle set
    step("clr_win",  0, 1, 8'h80, 8'h00, 8'h80, 8'h80, 0);
    step("clr_rel",  0, 0, 8'h80, 8'h00, 8'h80, 8'h80, 1);

    // mid-operation reset
    step("pre_rst",  0, 0, 8'h3C, 8'h00, 8'h3C, 8'h3C, 1);
    step("mid_rst",  1, 0, 8'h11, 8'h22, 8'h33, 8'h00, 0);
    step("post_rst", 0, 0, 8'h11, 8'h22, 8'h33, 8'h33, 1);

    // truth table on the 1-bit instance
    tt("tt00", 0, 0, 0);
    tt("tt10", 1, 0, 1);
    tt("tt01", 0, 1, 1);
    tt("tt11", 1, 1, 1);

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
